// File: rtl/mio_arbiter.sv
// mio_arbiter: two-master arbiter and access sequencer for the shared MIO bus.
// Requester 0 is the multi-cycle CPU controller and requester 1 is the
// DMA/display-fetch engine. Each granted access holds mem_ce for MEM_LAT
// cycles, then the owner gets a single-cycle completion pulse.
//
// Optional feature macro: MIO_ARB_RR_EN
//   defined     -> round-robin arbitration on contention (alternate owners)
//   not defined -> fixed priority, CPU always wins contention
//
// Reset is asynchronous and active-low on the port named 'reset'.

module mio_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        MIO_ready,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,

    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Owner encoding used for both the current owner and last_grant.
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    // Counter preload: the access lasts cnt+1 cycles, so MEM_LAT-1 gives MEM_LAT.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       owner;
    logic       last_grant;
    logic       cpu_wins;

    // Arbitration decision, only acted on in IDLE when some request is high.
    always_comb begin
        cpu_wins = 1'b0;
`ifdef MIO_ARB_RR_EN
        if (cpu_req && dma_req) begin
            cpu_wins = (last_grant == OWNER_DMA);
        end else begin
            cpu_wins = cpu_req;
        end
`else
        cpu_wins = cpu_req;
`endif
    end

`ifndef MIO_ARB_RR_EN
    // Under fixed priority last_grant is kept up to date but never consulted.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Access sequencer: IDLE -> ACCESS (MEM_LAT cycles) -> DONE (pulse) -> IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            owner      <= OWNER_CPU;
            last_grant <= OWNER_DMA;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            grant      <= 2'b00;
            cpu_rdata  <= 32'd0;
            dma_rdata  <= 32'd0;
            MIO_ready  <= 1'b0;
            dma_ack    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        state  <= ACCESS;
                        cnt    <= CNT_INIT;
                        mem_ce <= 1'b1;
                        if (cpu_wins) begin
                            owner     <= OWNER_CPU;
                            grant     <= 2'b01;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end else begin
                            owner     <= OWNER_DMA;
                            grant     <= 2'b10;
                            mem_we    <= dma_we;
                            mem_addr  <= dma_addr;
                            mem_wdata <= dma_wdata;
                        end
                    end
                end

                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state  <= DONE;
                        mem_ce <= 1'b0;
                        grant  <= 2'b00;
                        if (owner == OWNER_CPU) begin
                            cpu_rdata <= mem_rdata;
                            MIO_ready <= 1'b1;
                        end else begin
                            dma_rdata <= mem_rdata;
                            dma_ack   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                DONE: begin
                    MIO_ready  <= 1'b0;
                    dma_ack    <= 1'b0;
                    last_grant <= owner;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
